// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default baud divisor and legal parameter ranges.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } uart_state_t;

    localparam int CLK_DIV_115200_12M = 104;
    localparam int CLK_DIV_MIN        = 2;
    localparam int DATA_WIDTH_MIN     = 1;
    localparam int DATA_WIDTH_MAX     = 8;
    localparam int STOP_BITS_MIN      = 1;
    localparam int STOP_BITS_MAX      = 2;

endpackage

// File: rtl/baud_gen.sv
// Free-running bit-period counter; tick marks the last cycle of each CLK_DIV-cycle bit.
module baud_gen #(
    parameter int CLK_DIV = 104
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops one FIFO entry per frame and shifts it out LSB-first as start/data/stop on a registered tx line.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = CLK_DIV_115200_12M,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] q,
    output logic                  re,
    output logic                  tx,
    output logic                  busy
);

    localparam int BIT_W = $clog2(DATA_WIDTH + 1);

    uart_state_t           state, state_n;
    logic [DATA_WIDTH-1:0] shreg, shreg_n;
    logic [BIT_W-1:0]      bit_cnt, bit_cnt_n;
    logic                  tx_n;
    logic                  tick;
    logic                  clr;

    // Hold the baud counter at zero until the start bit so every bit gets a full CLK_DIV.
    assign clr  = (state == ST_IDLE) || (state == ST_WAIT);
    assign busy = (state != ST_IDLE);

    baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        re        = 1'b0;
        case (state)
            ST_IDLE: begin
                // Gated by rst so no entry is popped while the block is held in reset.
                re = en & ~empty & ~rst;
                if (re)
                    state_n = ST_WAIT;
            end
            ST_WAIT: begin
                shreg_n   = q;
                bit_cnt_n = '0;
                state_n   = ST_START;
            end
            ST_START: begin
                if (tick)
                    state_n = ST_DATA;
            end
            ST_DATA: begin
                if (tick) begin
                    shreg_n = shreg >> 1;
                    if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
                        bit_cnt_n = '0;
                        state_n   = ST_STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                // bit_cnt is reused to count stop bits.
                if (tick) begin
                    if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                        bit_cnt_n = '0;
                        state_n   = ST_IDLE;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // tx is decoded from next-state so the registered line lines up with the state register.
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            ST_START: tx_n = 1'b0;
            ST_DATA:  tx_n = shreg_n[0];
            default:  tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            bit_cnt <= bit_cnt_n;
            tx      <= tx_n;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two parameter sets, each fed by a small FIFO model and checked against frame arithmetic.
module tb_fifo_uart_tx;

    localparam int CD_A = 4, DW_A = 8, SB_A = 1;
    localparam int CD_B = 2, DW_B = 5, SB_B = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en_a = 1'b1, en_b = 1'b1;
    logic sel = 1'b0;

    logic [7:0] mem_a [0:63];
    logic [7:0] mem_b [0:63];
    int wp_a = 0, rp_a = 0, wp_b = 0, rp_b = 0;

    logic            empty_a, empty_b;
    logic [DW_A-1:0] q_a = '0;
    logic [DW_B-1:0] q_b = '0;
    logic            re_a, tx_a, busy_a, re_b, tx_b, busy_b;
    logic            re_a_q = 1'b0, re_b_q = 1'b0;
    logic            re_s, tx_s, busy_s;

    int cyc = 0;
    int n_chk = 0, n_fail = 0;

    assign empty_a = (wp_a == rp_a);
    assign empty_b = (wp_b == rp_b);
    assign re_s    = sel ? re_b   : re_a;
    assign tx_s    = sel ? tx_b   : tx_a;
    assign busy_s  = sel ? busy_b : busy_a;

    fifo_uart_tx #(.DATA_WIDTH(DW_A), .CLK_DIV(CD_A), .STOP_BITS(SB_A)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .empty(empty_a), .q(q_a),
        .re(re_a), .tx(tx_a), .busy(busy_a)
    );

    fifo_uart_tx #(.DATA_WIDTH(DW_B), .CLK_DIV(CD_B), .STOP_BITS(SB_B)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .empty(empty_b), .q(q_b),
        .re(re_b), .tx(tx_b), .busy(busy_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: re is sampled mid-cycle, data appears the cycle after the pop.
    always @(negedge clk) begin
        re_a_q <= re_a;
        re_b_q <= re_b;
    end

    always @(posedge clk) begin
        if (re_a_q) begin
            q_a  <= mem_a[rp_a % 64];
            rp_a <= rp_a + 1;
        end
        if (re_b_q) begin
            q_b  <= mem_b[rp_b % 64][DW_B-1:0];
            rp_b <= rp_b + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input bit b, input logic [7:0] v);
        if (b) begin
            mem_b[wp_b % 64] = v;
            wp_b++;
        end else begin
            mem_a[wp_a % 64] = v;
            wp_a++;
        end
    endtask

    // Line level k cycles after the start bit begins: start, LSB-first data, then stop bits.
    function automatic logic exp_bit(input logic [7:0] v, input int k, input int cd, input int dw);
        int idx;
        idx = k / cd;
        if (idx == 0) return 1'b0;
        if (idx <= dw) return v[idx-1];
        return 1'b1;
    endfunction

    task automatic wait_re(output int rc, output bit ok);
        ok = 1'b0;
        rc = -1;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (re_s === 1'b1) begin
                ok = 1'b1;
                rc = cyc;
            end
        end
        chk("re_seen", {31'd0, ok}, 32'd1);
    endtask

    task automatic run_frame(input logic [7:0] v, input int drop_k, output int rc);
        bit ok;
        int cd, dw, sb, flen;
        cd   = sel ? CD_B : CD_A;
        dw   = sel ? DW_B : DW_A;
        sb   = sel ? SB_B : SB_A;
        flen = (1 + dw + sb) * cd;
        wait_re(rc, ok);
        if (!ok) return;
        chk("idle_busy", {31'd0, busy_s}, 32'd0);
        chk("idle_tx", {31'd0, tx_s}, 32'd1);
        for (int k = 1; k <= flen + 1; k++) begin
            @(negedge clk);
            if (k == drop_k) begin
                if (sel) en_b = 1'b0;
                else     en_a = 1'b0;
            end
            chk("re_single", {31'd0, re_s}, 32'd0);
            chk("busy_frame", {31'd0, busy_s}, 32'd1);
            chk($sformatf("tx_k%0d_v%0h", k, v), {31'd0, tx_s},
                {31'd0, (k == 1) ? 1'b1 : exp_bit(v, k - 2, cd, dw)});
        end
    endtask

    initial begin
        int r1, r2, ec;
        bit ok;
        logic [7:0] vals [8];

        // Reset
        repeat (3) @(negedge clk);
        chk("rst_tx_a", {31'd0, tx_a}, 32'd1);
        chk("rst_re_a", {31'd0, re_a}, 32'd0);
        chk("rst_busy_a", {31'd0, busy_a}, 32'd0);
        chk("rst_tx_b", {31'd0, tx_b}, 32'd1);
        chk("rst_busy_b", {31'd0, busy_b}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_re", {31'd0, re_a}, 32'd0);
            chk("idle_tx", {31'd0, tx_a}, 32'd1);
            chk("idle_busy", {31'd0, busy_a}, 32'd0);
        end

        // Single byte
        sel = 1'b0;
        @(posedge clk); #1 push(0, 8'hA5);
        run_frame(8'hA5, -1, r1);
        @(negedge clk);
        chk("busy_fall", {31'd0, busy_a}, 32'd0);
        chk("busy_fall_cyc", cyc - r1, 32'd42);

        // Back-to-back
        @(posedge clk); #1 push(0, 8'h00); push(0, 8'hFF);
        run_frame(8'h00, -1, r1);
        run_frame(8'hFF, -1, r2);
        chk("b2b_period", r2 - r1, 32'd42);

        // Enable gating
        @(posedge clk); #1 push(0, 8'h3C); push(0, 8'h11); push(0, 8'h22);
        run_frame(8'h3C, 12, r1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("gated_re", {31'd0, re_a}, 32'd0);
            chk("gated_busy", {31'd0, busy_a}, 32'd0);
        end
        @(posedge clk); #1 en_a = 1'b1;
        ec = cyc;
        run_frame(8'h11, -1, r1);
        chk("re_after_en", r1 - ec, 32'd0);
        run_frame(8'h22, -1, r2);
        chk("en_period", r2 - r1, 32'd42);

        // Reset during data bit 3 of 0x5A
        @(posedge clk); #1 push(0, 8'h5A); push(0, 8'hC3);
        wait_re(r1, ok);
        repeat (19) @(negedge clk);
        chk("pre_rst_bit3", {31'd0, tx_a}, 32'd1);
        chk("pre_rst_busy", {31'd0, busy_a}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_tx", {31'd0, tx_a}, 32'd1);
        chk("rst_async_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_async_re", {31'd0, re_a}, 32'd0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        run_frame(8'hC3, -1, r1);

        // Second parameter set
        sel = 1'b1;
        @(posedge clk); #1 push(1, 8'h13); push(1, 8'h0A);
        run_frame(8'h13, -1, r1);
        run_frame(8'h0A, -1, r2);
        chk("b_period", r2 - r1, 32'd18);

        // Random back-to-back streams on both instances
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            @(posedge clk); #1;
            for (int i = 0; i < 8; i++) begin
                vals[i] = 8'($urandom_range(0, 255));
                if (s == 1) vals[i] = vals[i] & 8'h1F;
                push(s == 1, vals[i]);
            end
            r1 = 0;
            for (int i = 0; i < 8; i++) begin
                run_frame(vals[i], -1, r2);
                if (i > 0) chk("rand_period", r2 - r1, (s == 1) ? 32'd18 : 32'd42);
                r1 = r2;
            end
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Drains the single-clock read side of the block-RAM FIFO and serialises each entry onto a UART TX line as an asynchronous 8N1-style frame (start bit, LSB-first data, stop bits). It sits directly downstream of the FIFO: it drives the FIFO's `re` and consumes its `q` and `empty`. It accounts for the one-cycle registered read latency of the iCE40 block RAM. It is the standard path for getting logged or streamed data off-chip.

## Interface
- `DATA_WIDTH`, default 8: bits per frame, legal range 1..8; matches the FIFO `DATA_WIDTH`.
- `CLK_DIV`, default 104: clock cycles per UART bit (12 MHz / 115200), minimum 2.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.

Ports:
- `clk` in 1: single clock; the FIFO read clock `r_clk` is tied to this clock.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: permits starting a new frame; a frame in progress always completes.
- `empty` in 1: FIFO empty flag.
- `q` in DATA_WIDTH: FIFO read data, valid the cycle after `re`.
- `re` out 1: FIFO pop strobe, exactly one cycle per frame.
- `tx` out 1: serial line, idle high.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- The FSM states are IDLE, WAIT, START, DATA and STOP.
- **IDLE**
  - `re = en & ~empty`, combinational in this state only.
  - If `re` is high, go to WAIT.
  - `empty` is sampled only in IDLE.
- **WAIT** (one cycle)
  - `q` is valid.
  - At the end of the cycle: shift register ← `q`, bit counter ← 0, baud counter ← 0; go to START.
- **START**
  - `tx` = 0 for CLK_DIV cycles; then go to DATA.
- **DATA**
  - `tx` = shreg[0] for CLK_DIV cycles per bit.
  - On each bit end, shift right.
  - After DATA_WIDTH bits, go to STOP.
- **STOP**
  - `tx` = 1 for STOP_BITS×CLK_DIV cycles; then go to IDLE.
- **Counters**
  - Baud counter width is clog2(CLK_DIV); it counts 0..CLK_DIV-1 and wraps.
  - Bit counter width is clog2(DATA_WIDTH+1).
  - Bit-end tick is asserted when the baud counter equals CLK_DIV-1.
- **Output registering**
  - `tx` is registered: its value is driven from the state and shreg of the previous edge, so there are no glitches.
  - `re` is a Moore-plus-input decode in IDLE only.
- **Boundary conditions**
  - `en` deasserted mid-frame: the frame completes; no new pop occurs.
  - `empty` rising during a frame: ignored.
  - `empty` low on entry to IDLE: pop immediately (back-to-back frames).
  - `rst` mid-frame: `tx` is forced to 1 immediately and the state goes to IDLE. The popped entry is lost and is not re-read.
- **Reset values**: `tx`=1, `re`=0, `busy`=0, state=IDLE, all counters 0, shreg 0.

## Timing
- Cycle N: IDLE with `re`=1.
- Cycle N+1: WAIT.
- Cycle N+2: `tx` falls (first start-bit cycle).
- Frame length on the wire is (1+DATA_WIDTH+STOP_BITS)×CLK_DIV cycles.
- Back-to-back frames have an idle-high gap of exactly 2 extra cycles (IDLE and WAIT) after the last stop cycle. The frame period is (1+DATA_WIDTH+STOP_BITS)×CLK_DIV+2.
- `busy` is high from cycle N+1 through the last STOP cycle inclusive.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding (3-bit).
  - `CLK_DIV_115200_12M` = 104.
  - Legal ranges for `STOP_BITS` and `DATA_WIDTH`.
- Sub-module `baud_gen`:
  - Parameter CLK_DIV; inputs `clk`, `rst`, `clr`; output `tick`.
  - Counter that clears on `clr` and pulses `tick` every CLK_DIV cycles.
  - Reused by the future UART RX.
- Top level is expected at roughly 150–250 lines of RTL.

## Test plan
- **Reset**: with `rst` high, `tx`=1, `re`=0, `busy`=0. Release with `empty`=1 and `en`=1 → outputs unchanged for 100 cycles.
- **Single byte**: CLK_DIV=4, DATA_WIDTH=8, FIFO holds 0xA5, `en`=1.
  - `re` pulses for exactly one cycle.
  - Two cycles later, `tx` shows the sequence 0,1,0,1,0,0,1,0,1,1, each value held for 4 cycles.
  - `busy` falls after 42 cycles from the `re` cycle.
- **Back-to-back**: FIFO holds 0x00 then 0xFF, CLK_DIV=4.
  - Second `re` occurs 42 cycles after the first.
  - `tx` is high for exactly 6 cycles between the frames.
- **Enable gating**: deassert `en` during the DATA bits of frame 1, with the FIFO non-empty.
  - Frame 1 completes; no further `re` is issued.
  - Re-asserting `en` → `re` on the next cycle.
- **Reset mid-frame**: assert `rst` during bit 3 of 0x5A.
  - `tx`=1 asynchronously, state IDLE.
  - After release, the next FIFO entry is sent, not 0x5A.
- **Parameters**: STOP_BITS=2, DATA_WIDTH=5, CLK_DIV=2, value 0x13.
  - `tx` sequence is 0,1,1,0,0,1,1,1, each value held for 2 cycles.
  - Frame period is 18 cycles.
